// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - CPU bus address constants and OAM DMA state encoding
//
// Shared by the CPU-bus blocks. Exports:
//   NES_OAMDMA_ADDR   CPU address whose write launches a sprite DMA ($4014)
//   NES_OAMDATA_ADDR  PPU OAMDATA register written once per byte ($2004)
//   NES_OAM_XFER_LEN  bytes copied per DMA
//   oam_dma_state_t   sequencer states
package nes_bus_pkg;

    localparam logic [15:0] NES_OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] NES_OAMDATA_ADDR = 16'h2004;
    localparam int          NES_OAM_XFER_LEN = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite OAM DMA sequencer for the CPU bus
//
// A CPU write to DMA_REG_ADDR halts the CPU, then the block owns the bus and
// copies XFER_LEN bytes from page {CPU_DATA_OUT,8'h00} to OAM_DATA_ADDR as
// alternating read/write cycles, and finally releases the bus.
//
// Build option: OAM_DMA_ALIGN_EN
//   defined   - a parity register tracks get/put cycles; a HALT that lands on
//               parity 0 inserts one dummy ALIGN read (513 or 514 halt cycles)
//   undefined - no parity, no ALIGN; HALT always goes to READ (513 cycles)
//
// Ports:
//   CLK, RESET          CPU clock, synchronous active-high reset
//   CPU_ENABLE          trigger qualifier from the top level
//   CPU_ADDR/CPU_RW_n   CPU bus cycle being observed for the trigger
//   CPU_DATA_OUT        CPU write data, source page number
//   DMA_DATA_IN         selected bus read data returned during READ
//   CPU_HALT            stall request; top gates CPU enable with ~CPU_HALT
//   DMA_ACTIVE          top muxes DMA_ADDR/DMA_RW_n/DMA_DATA_OUT onto the bus
//   DMA_ADDR/DMA_RW_n/DMA_DATA_OUT  bus cycle driven by the sequencer
//   DMA_DONE            one-cycle pulse after the final OAMDATA write
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = NES_OAMDMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = NES_OAMDATA_ADDR,
    parameter int          XFER_LEN      = NES_OAM_XFER_LEN
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_ENABLE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DATA_OUT,
    input  logic        CPU_RW_n,
    input  logic [7:0]  DMA_DATA_IN,
    output logic        CPU_HALT,
    output logic        DMA_ACTIVE,
    output logic [15:0] DMA_ADDR,
    output logic        DMA_RW_n,
    output logic [7:0]  DMA_DATA_OUT,
    output logic        DMA_DONE
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    oam_dma_state_t state_q, state_d;
    logic [7:0]     page_q;
    logic [7:0]     idx_q;
    logic [7:0]     latch_q;
    logic           trigger;
    logic           last_byte;

`ifdef OAM_DMA_ALIGN_EN
    // Free-running get/put phase; reads are only allowed on parity 0.
    logic parity_q;
`endif

    // Only IDLE accepts a launch; once halted the CPU cannot issue another.
    assign trigger   = (state_q == IDLE) && CPU_ENABLE && !CPU_RW_n
                       && (CPU_ADDR == DMA_REG_ADDR);
    assign last_byte = (idx_q == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            latch_q <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= ~parity_q;
`endif
            if (trigger) begin
                page_q <= CPU_DATA_OUT;
                idx_q  <= 8'h00;
            end
            if (state_q == READ) begin
                latch_q <= DMA_DATA_IN;
            end
            // idx stops at the last byte so the address never leaves the page.
            if ((state_q == WRITE) && !last_byte) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        CPU_HALT     = 1'b0;
        DMA_ACTIVE   = 1'b0;
        DMA_ADDR     = 16'h0000;
        DMA_RW_n     = 1'b1;
        DMA_DATA_OUT = 8'h00;
        DMA_DONE     = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // CPU is still completing its write to the DMA register.
                CPU_HALT = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? READ : ALIGN;
`else
                state_d = READ;
`endif
            end
            ALIGN: begin
                // Dummy read to land the first real read on a get cycle.
                CPU_HALT   = 1'b1;
                DMA_ACTIVE = 1'b1;
                DMA_ADDR   = {page_q, idx_q};
                state_d    = READ;
            end
            READ: begin
                CPU_HALT   = 1'b1;
                DMA_ACTIVE = 1'b1;
                DMA_ADDR   = {page_q, idx_q};
                state_d    = WRITE;
            end
            WRITE: begin
                CPU_HALT     = 1'b1;
                DMA_ACTIVE   = 1'b1;
                DMA_RW_n     = 1'b0;
                DMA_ADDR     = OAM_DATA_ADDR;
                DMA_DATA_OUT = latch_q;
                state_d      = last_byte ? DONE : READ;
            end
            DONE: begin
                DMA_DONE = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - directed self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_ENABLE;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_OUT;
    logic        CPU_RW_n;
    logic [7:0]  DMA_DATA_IN;
    logic        CPU_HALT;
    logic        DMA_ACTIVE;
    logic [15:0] DMA_ADDR;
    logic        DMA_RW_n;
    logic [7:0]  DMA_DATA_OUT;
    logic        DMA_DONE;

    oam_dma_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CPU_ENABLE   (CPU_ENABLE),
        .CPU_ADDR     (CPU_ADDR),
        .CPU_DATA_OUT (CPU_DATA_OUT),
        .CPU_RW_n     (CPU_RW_n),
        .DMA_DATA_IN  (DMA_DATA_IN),
        .CPU_HALT     (CPU_HALT),
        .DMA_ACTIVE   (DMA_ACTIVE),
        .DMA_ADDR     (DMA_ADDR),
        .DMA_RW_n     (DMA_RW_n),
        .DMA_DATA_OUT (DMA_DATA_OUT),
        .DMA_DONE     (DMA_DONE)
    );

    always #5 CLK = ~CLK;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    // Bus memory: SYSRAM pages and PRG-ROM share one flat image here.
    logic [7:0] mem [0:65535];
    assign DMA_DATA_IN = mem[DMA_ADDR];

    int          n_vec = 0;
    int          n_err = 0;
    int          halt_cnt;
    int          done_cnt;
    logic [7:0]  wr_log [$];
    logic [15:0] rd_log [$];
    logic        tb_par;

    // Reference get/put phase.
    always @(posedge CLK) tb_par <= RESET ? 1'b0 : ~tb_par;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (CPU_HALT) halt_cnt++;
            if (DMA_DONE) done_cnt++;
            if (DMA_ACTIVE && !DMA_RW_n && DMA_ADDR == 16'h2004) wr_log.push_back(DMA_DATA_OUT);
            if (DMA_ACTIVE && DMA_RW_n) rd_log.push_back(DMA_ADDR);
        end
    end

    function automatic logic [7:0] pat(input logic [7:0] pg, input logic [7:0] i);
        case (pg)
            8'h02:   return i ^ 8'h5A;
            8'h03:   return i + 8'h33;
            default: return {i[3:0], i[7:4]} ^ 8'hC3;
        endcase
    endfunction

    function automatic int exp_halt(input logic hp);
        return (ALIGN_ON && !hp) ? 514 : 513;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        halt_cnt = 0;
        done_cnt = 0;
        wr_log.delete();
        rd_log.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 of the HALT cycle.
    task automatic trigger(input logic [7:0] pg);
        CPU_ENABLE   = 1'b1;
        CPU_RW_n     = 1'b0;
        CPU_ADDR     = 16'h4014;
        CPU_DATA_OUT = pg;
        @(posedge CLK); #1;
        CPU_ENABLE   = 1'b0;
        CPU_RW_n     = 1'b1;
        CPU_ADDR     = 16'h0000;
        CPU_DATA_OUT = 8'h00;
    endtask

    // HALT parity equals ~tb_par sampled before the trigger edge.
    task automatic start_xfer(input logic [7:0] pg, input logic want_par, output int exp_h);
        if (tb_par == want_par) begin
            @(posedge CLK); #1;
        end
        exp_h = exp_halt(~tb_par);
        clear_logs();
        trigger(pg);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(negedge CLK);
            if (DMA_DONE) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] pg, input int exp_h);
        int bad_wr = 0;
        int bad_rd = 0;
        int base;
        chk({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(exp_h));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_write_count"}, 32'(wr_log.size()), 32'd256);
        chk({tag, "_read_count"}, 32'(rd_log.size()), 32'(exp_h - 257));
        for (int i = 0; i < wr_log.size() && i < 256; i++)
            if (wr_log[i] !== pat(pg, 8'(i))) bad_wr++;
        chk({tag, "_write_data_errs"}, 32'(bad_wr), 32'd0);
        base = rd_log.size() - 256;
        if (base < 0) base = 0;
        for (int i = 0; i < 256 && base + i < rd_log.size(); i++)
            if (rd_log[base + i] !== {pg, 8'(i)}) bad_rd++;
        chk({tag, "_read_addr_errs"}, 32'(bad_rd), 32'd0);
    endtask

    initial begin
        int  eh;
        int  eh2;
        bit  found;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[{8'h02, 8'(i)}] = pat(8'h02, 8'(i));
            mem[{8'h03, 8'(i)}] = pat(8'h03, 8'(i));
            mem[{8'hFF, 8'(i)}] = pat(8'hFF, 8'(i));
        end

        RESET        = 1'b1;
        CPU_ENABLE   = 1'b0;
        CPU_ADDR     = 16'h0000;
        CPU_DATA_OUT = 8'h00;
        CPU_RW_n     = 1'b1;
        clear_logs();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cpu_halt", 32'(CPU_HALT), 32'd0);
        chk("rst_dma_active", 32'(DMA_ACTIVE), 32'd0);
        chk("rst_dma_addr", 32'(DMA_ADDR), 32'h0000);
        chk("rst_dma_rw_n", 32'(DMA_RW_n), 32'd1);
        chk("rst_dma_data", 32'(DMA_DATA_OUT), 32'h00);
        chk("rst_dma_done", 32'(DMA_DONE), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Page $02, parity 0 at HALT.
        start_xfer(8'h02, 1'b0, eh);
        wait_done("p0");
        check_xfer("p0", 8'h02, eh);
        chk("p0_done_releases_halt", 32'(CPU_HALT), 32'd0);

        // Page $02, parity 1 at HALT.
        @(posedge CLK); #1;
        start_xfer(8'h02, 1'b1, eh);
        wait_done("p1");
        check_xfer("p1", 8'h02, eh);

        // Non-trigger accesses: $4015 write, $4014 read, $4014 write with enable low.
        @(posedge CLK); #1;
        clear_logs();
        CPU_ENABLE = 1'b1; CPU_RW_n = 1'b0; CPU_ADDR = 16'h4015; CPU_DATA_OUT = 8'h02;
        @(posedge CLK); #1;
        CPU_RW_n = 1'b1; CPU_ADDR = 16'h4014;
        @(posedge CLK); #1;
        CPU_ENABLE = 1'b0; CPU_RW_n = 1'b0;
        @(posedge CLK); #1;
        CPU_RW_n = 1'b1; CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00;
        repeat (4) @(posedge CLK);
        @(negedge CLK); #1;
        chk("nt_halt_cycles", 32'(halt_cnt), 32'd0);
        chk("nt_bus_cycles", 32'(rd_log.size() + wr_log.size()), 32'd0);
        chk("nt_dma_active", 32'(DMA_ACTIVE), 32'd0);

        // Page $FF, reset while reading idx $40.
        @(posedge CLK); #1;
        start_xfer(8'hFF, 1'b0, eh);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (DMA_ACTIVE && DMA_RW_n && DMA_ADDR == 16'hFF40) begin
                found = 1'b1;
                break;
            end
        end
        chk("rm_read40_seen", 32'(found), 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rm_cpu_halt", 32'(CPU_HALT), 32'd0);
        chk("rm_dma_active", 32'(DMA_ACTIVE), 32'd0);
        chk("rm_dma_done", 32'(DMA_DONE), 32'd0);
        repeat (5) @(negedge CLK);
        #1;
        chk("rm_done_pulses", 32'(done_cnt), 32'd0);
        chk("rm_write_count", 32'(wr_log.size()), 32'd64);
        begin
            int bad = 0;
            for (int i = 0; i < wr_log.size(); i++)
                if (wr_log[i] !== pat(8'hFF, 8'(i))) bad++;
            chk("rm_write_data_errs", 32'(bad), 32'd0);
        end

        // Back-to-back: $03 launched in the IDLE cycle right after DONE.
        @(posedge CLK); #1;
        start_xfer(8'h02, 1'b0, eh);
        wait_done("bb1");
        @(posedge CLK); #1;
        check_xfer("bb1", 8'h02, eh);
        eh2 = exp_halt(~tb_par);
        clear_logs();
        trigger(8'h03);
        @(negedge CLK);
        chk("bb2_immediate_halt", 32'(CPU_HALT), 32'd1);
        wait_done("bb2");
        check_xfer("bb2", 8'h03, eh2);

        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
